// File: rtl/bram_a_wb_arbiter_pkg.sv
// Shared defaults and arbiter-choice encoding for the BRAM A port-0 writeback arbiter.
package bram_a_wb_arbiter_pkg;

  localparam int unsigned DEF_DESIGN_SIZE = 4;
  localparam int unsigned DEF_DWIDTH      = 8;
  localparam int unsigned DEF_AWIDTH      = 10;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_sel_e;

endpackage

// File: rtl/bram_a_wb_arbiter_if.sv
// Matmul read request, output-stage write handshake and BRAM A port-0 signals.
interface bram_a_wb_arbiter_if #(
  parameter int unsigned DESIGN_SIZE = 4,
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned AWIDTH      = 10
) ();

  logic                          rd_req;
  logic [AWIDTH-1:0]             rd_addr;
  logic                          rd_gnt;
  logic                          wr_valid;
  logic [DESIGN_SIZE*DWIDTH-1:0] wr_data;
  logic                          wr_ready;
  logic [AWIDTH-1:0]             bram_addr;
  logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata;
  logic [DESIGN_SIZE-1:0]        bram_we;

  modport master (
    output rd_req, rd_addr, wr_valid, wr_data,
    input  rd_gnt, wr_ready, bram_addr, bram_wdata, bram_we
  );

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_data,
    output rd_gnt, wr_ready, bram_addr, bram_wdata, bram_we
  );

endinterface

// File: rtl/bram_a_wb_arbiter_wb_fifo.sv
// First-word-fall-through writeback buffer; head is visible on dout while level != 0.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/bram_a_wb_arbiter.sv
// Arbitrates BRAM A port 0 between matmul reads and buffered output-stage writeback,
// generating writeback addresses in matmul (descending stride) or conv (ascending step) mode.
module bram_a_wb_arbiter
  import bram_a_wb_arbiter_pkg::*;
#(
  parameter int unsigned DESIGN_SIZE = DEF_DESIGN_SIZE,
  parameter int unsigned DWIDTH      = DEF_DWIDTH,
  parameter int unsigned AWIDTH      = DEF_AWIDTH,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] address_mat_c,
  input  logic [AWIDTH-1:0] address_stride_c,
  input  logic              enable_conv_mode,
  input  logic [AWIDTH-1:0] conv_addr_step,
  bram_a_wb_arbiter_if.slave bus,
  output logic [LW-1:0]     fifo_level,
  output logic [15:0]       wb_count,
  output logic              start_err
);

  localparam int unsigned WW = DESIGN_SIZE * DWIDTH;

  logic [WW-1:0]     fifo_head;
  logic [LW-1:0]     level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              start_ok;
  arb_sel_e          arb_sel;

  logic              rd_gnt;
  logic [AWIDTH-1:0] bram_addr;
  logic [WW-1:0]     bram_wdata;
  logic [DESIGN_SIZE-1:0] bram_we;

  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic              conv_mode_q, conv_mode_d;
  logic [AWIDTH-1:0] stride_q, stride_d;
  logic [AWIDTH-1:0] step_q, step_d;
  logic [15:0]       wb_count_q, wb_count_d;
  logic              start_err_q, start_err_d;

  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign push       = bus.wr_valid && !fifo_full;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WW),
    .LW    (LW)
  ) u_wb_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.wr_data),
    .pop   (pop),
    .dout  (fifo_head),
    .level (level)
  );

  // A full buffer takes priority so a push can never arrive while full.
  always_comb begin
    arb_sel = ARB_IDLE;
    if (fifo_full) begin
      arb_sel = ARB_WRITE;
    end else if (bus.rd_req) begin
      arb_sel = ARB_READ;
    end else if (!fifo_empty) begin
      arb_sel = ARB_WRITE;
    end
  end

  always_comb begin
    rd_gnt     = 1'b0;
    pop        = 1'b0;
    bram_addr  = bus.rd_addr;
    bram_wdata = '0;
    bram_we    = '0;
    case (arb_sel)
      ARB_READ: begin
        rd_gnt = 1'b1;
      end
      ARB_WRITE: begin
        pop        = 1'b1;
        bram_addr  = wr_addr_q;
        bram_wdata = fifo_head;
        bram_we    = '1;
      end
      default: ;
    endcase
  end

  assign start_ok = start && fifo_empty;

  // Mode and steps are captured at start so mid-run input changes cannot disturb addressing.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    conv_mode_d = conv_mode_q;
    stride_d    = stride_q;
    step_d      = step_q;
    wb_count_d  = wb_count_q;
    start_err_d = start_err_q;
    if (start_ok) begin
      wr_addr_d   = address_mat_c;
      conv_mode_d = enable_conv_mode;
      stride_d    = address_stride_c;
      step_d      = conv_addr_step;
      wb_count_d  = '0;
    end else begin
      if (start) begin
        start_err_d = 1'b1;
      end
      if (pop) begin
        wr_addr_d  = conv_mode_q ? (wr_addr_q + step_q) : (wr_addr_q - stride_q);
        wb_count_d = wb_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q   <= '0;
      conv_mode_q <= 1'b0;
      stride_q    <= '0;
      step_q      <= '0;
      wb_count_q  <= '0;
      start_err_q <= 1'b0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      conv_mode_q <= conv_mode_d;
      stride_q    <= stride_d;
      step_q      <= step_d;
      wb_count_q  <= wb_count_d;
      start_err_q <= start_err_d;
    end
  end

  assign bus.rd_gnt     = rd_gnt;
  assign bus.wr_ready   = !fifo_full;
  assign bus.bram_addr  = bram_addr;
  assign bus.bram_wdata = bram_wdata;
  assign bus.bram_we    = bram_we;

  assign fifo_level = level;
  assign wb_count   = wb_count_q;
  assign start_err  = start_err_q;

endmodule

// File: tb/tb_bram_a_wb_arbiter.sv
// Directed bench for bram_a_wb_arbiter; expected writes are queued at push time and
// matched against BRAM write cycles by a negedge monitor.
module tb_bram_a_wb_arbiter;

  localparam int DS = 4;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int FD = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] address_mat_c;
  logic [AW-1:0] address_stride_c;
  logic          enable_conv_mode;
  logic [AW-1:0] conv_addr_step;
  logic [LW-1:0] fifo_level;
  logic [15:0]   wb_count;
  logic          start_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_exp_t;

  wr_exp_t sb_q[$];

  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_stride;
  logic [AW-1:0] m_step;
  logic          m_conv;

  bram_a_wb_arbiter_if #(.DESIGN_SIZE(DS), .DWIDTH(DW), .AWIDTH(AW)) bus ();

  bram_a_wb_arbiter #(
    .DESIGN_SIZE (DS),
    .DWIDTH      (DW),
    .AWIDTH      (AW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .address_mat_c    (address_mat_c),
    .address_stride_c (address_stride_c),
    .enable_conv_mode (enable_conv_mode),
    .conv_addr_step   (conv_addr_step),
    .bus              (bus),
    .fifo_level       (fifo_level),
    .wb_count         (wb_count),
    .start_err        (start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic conv, input logic [AW-1:0] step);
    start            = 1'b1;
    address_mat_c    = base;
    address_stride_c = stride;
    enable_conv_mode = conv;
    conv_addr_step   = step;
    m_addr   = base;
    m_stride = stride;
    m_conv   = conv;
    m_step   = step;
  endtask

  task automatic push_word(input logic [31:0] d);
    wr_exp_t e;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    e.addr = m_addr;
    e.data = d;
    sb_q.push_back(e);
    m_addr = m_conv ? (m_addr + m_step) : (m_addr - m_stride);
  endtask

  // Every BRAM write must match the oldest outstanding pushed word.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.bram_we !== 4'b0000) begin
      wr_exp_t e;
      chk("we_lanes", 32'(bus.bram_we), 32'hF);
      tests++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL wr_unexpected: observed write at %0h expected no write", bus.bram_addr);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_addr", 32'(bus.bram_addr), 32'(e.addr));
        chk("sb_data", bus.bram_wdata, e.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish expected finish before 50000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    address_mat_c = '0;
    address_stride_c = '0;
    enable_conv_mode = 1'b0;
    conv_addr_step = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    m_addr = '0; m_stride = '0; m_step = '0; m_conv = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_we", 32'(bus.bram_we), 0);
    chk("rst_wdata", bus.bram_wdata, 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 1);
    chk("rst_wb_count", 32'(wb_count), 0);
    chk("rst_start_err", 32'(start_err), 0);
    bus.rd_req = 1'b1;
    #1 chk("rst_rd_gnt1", 32'(bus.rd_gnt), 1);
    bus.rd_req = 1'b0;
    #1 chk("rst_rd_gnt0", 32'(bus.rd_gnt), 0);
    tick();
    reset = 1'b0;

    // Matmul mode, word pushed in the start cycle, stride changed mid-run
    begin_run(10'h040, 10'd4, 1'b0, 10'd0);
    push_word(32'hA0A0_0001);
    @(negedge clk); chk("t1_start_we", 32'(bus.bram_we), 0);
    tick();
    start = 1'b0; address_stride_c = 10'd8; address_mat_c = 10'h123;
    push_word(32'hA0A0_0002);
    @(negedge clk); chk("t1_w0_addr", 32'(bus.bram_addr), 32'h040); chk("t1_lvl", 32'(fifo_level), 1);
    tick();
    push_word(32'hA0A0_0003);
    @(negedge clk); chk("t1_w1_addr", 32'(bus.bram_addr), 32'h03C);
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk); chk("t1_w2_addr", 32'(bus.bram_addr), 32'h038);
    tick();
    @(negedge clk);
    chk("t1_idle_we", 32'(bus.bram_we), 0);
    chk("t1_idle_wdata", bus.bram_wdata, 0);
    chk("t1_wb_count", 32'(wb_count), 3);
    chk("t1_lvl_end", 32'(fifo_level), 0);
    tick();

    // Conv mode, step input changed after start
    begin_run(10'h010, 10'd5, 1'b1, 10'd16);
    tick();
    start = 1'b0; conv_addr_step = 10'd99; enable_conv_mode = 1'b0;
    push_word(32'hB0B0_0001);
    tick();
    push_word(32'hB0B0_0002);
    @(negedge clk); chk("t2_w0_addr", 32'(bus.bram_addr), 32'h010);
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk); chk("t2_w1_addr", 32'(bus.bram_addr), 32'h020);
    tick();
    @(negedge clk); chk("t2_wb_count", 32'(wb_count), 2);
    tick();

    // Address wrap below zero
    begin_run(10'h002, 10'd4, 1'b0, 10'd0);
    push_word(32'hC0C0_0001);
    tick();
    start = 1'b0;
    push_word(32'hC0C0_0002);
    @(negedge clk); chk("t3_w0_addr", 32'(bus.bram_addr), 32'h002);
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk); chk("t3_w1_addr", 32'(bus.bram_addr), 32'h3FE);
    tick();

    // Reads win until the buffer fills, then one forced write
    begin_run(10'h100, 10'd1, 1'b0, 10'd0);
    bus.rd_req = 1'b1; bus.rd_addr = 10'h055;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(32'hD0D0_0000 + 32'(i));
      @(negedge clk);
      chk("t4_gnt", 32'(bus.rd_gnt), 1);
      chk("t4_rd_addr", 32'(bus.bram_addr), 32'h055);
      chk("t4_rd_we", 32'(bus.bram_we), 0);
      chk("t4_lvl", 32'(fifo_level), 32'(i));
      tick();
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("t4_full_lvl", 32'(fifo_level), 4);
    chk("t4_full_gnt", 32'(bus.rd_gnt), 0);
    chk("t4_full_ready", 32'(bus.wr_ready), 0);
    chk("t4_full_addr", 32'(bus.bram_addr), 32'h100);
    tick();
    @(negedge clk);
    chk("t4_resume_gnt", 32'(bus.rd_gnt), 1);
    chk("t4_resume_ready", 32'(bus.wr_ready), 1);
    chk("t4_resume_lvl", 32'(fifo_level), 3);
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk); chk("t4_d0_addr", 32'(bus.bram_addr), 32'h0FF);
    tick();
    @(negedge clk); chk("t4_d1_addr", 32'(bus.bram_addr), 32'h0FE);
    tick();
    @(negedge clk); chk("t4_d2_addr", 32'(bus.bram_addr), 32'h0FD);
    tick();
    @(negedge clk);
    chk("t4_lvl_end", 32'(fifo_level), 0);
    chk("t4_wb_count", 32'(wb_count), 4);
    tick();

    // Start while buffer holds two words is rejected
    begin_run(10'h200, 10'd2, 1'b0, 10'd0);
    push_word(32'hE0E0_0001);
    tick();
    start = 1'b0; bus.wr_valid = 1'b0;
    @(negedge clk); chk("t5_w0_addr", 32'(bus.bram_addr), 32'h200);
    tick();
    bus.rd_req = 1'b1;
    push_word(32'hE0E0_0002);
    tick();
    push_word(32'hE0E0_0003);
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("t5_lvl2", 32'(fifo_level), 2);
    chk("t5_cnt_pre", 32'(wb_count), 1);
    tick();
    start = 1'b1; address_mat_c = 10'h3AA; address_stride_c = 10'd7;
    enable_conv_mode = 1'b1; conv_addr_step = 10'd3; bus.rd_req = 1'b0;
    @(negedge clk);
    chk("t5_old_addr", 32'(bus.bram_addr), 32'h1FE);
    chk("t5_err_pre", 32'(start_err), 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t5_err", 32'(start_err), 1);
    chk("t5_old_addr2", 32'(bus.bram_addr), 32'h1FC);
    tick();
    @(negedge clk);
    chk("t5_wb_count", 32'(wb_count), 3);
    chk("t5_lvl_end", 32'(fifo_level), 0);
    chk("t5_err_sticky", 32'(start_err), 1);
    tick();

    // Async reset mid-cycle discards three buffered words
    bus.rd_req = 1'b1; bus.rd_addr = 10'h077;
    for (int i = 0; i < 3; i++) begin
      push_word(32'hF0F0_0000 + 32'(i));
      tick();
    end
    bus.wr_valid = 1'b0;
    @(negedge clk); chk("t6_lvl3", 32'(fifo_level), 3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    sb_q.delete();
    #1;
    chk("t6_rst_lvl", 32'(fifo_level), 0);
    chk("t6_rst_we", 32'(bus.bram_we), 0);
    chk("t6_rst_wdata", bus.bram_wdata, 0);
    chk("t6_rst_gnt", 32'(bus.rd_gnt), 1);
    chk("t6_rst_ready", 32'(bus.wr_ready), 1);
    chk("t6_rst_err", 32'(start_err), 0);
    chk("t6_rst_cnt", 32'(wb_count), 0);
    tick();
    reset = 1'b0;
    bus.rd_req = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("t6_post_lvl", 32'(fifo_level), 0);
    chk("t6_post_cnt", 32'(wb_count), 0);

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
